cpu_mem_ram: RTL and testbench

Parametrised, writable program/data memory for the SAP CPU. It replaces the fixed 16×8 mask ROM with a clocked array of 2^ADDR_W words of DATA_W bits. It has an internal MAR, a registered read port gated onto the CPU bus, a CPU write strobe, and a handshaked sequential programming port with auto-increment. The programming port loads the program before the CPU is released from halt. The block sits between the CPU bus and the controller, in the slot previously held by the ROM.

---
 rtl/cpu_mem_pkg.sv | 18 +
 rtl/cpu_mem_prog_ctrl.sv | 105 ++++++++++
 rtl/cpu_mem_ram.sv | 105 ++++++++++
 tb/tb_cpu_mem_ram.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the SAP CPU program/data memory:
//   - default word and address widths, also used by the CPU top
//   - state encoding of the sequential programming port
// -----------------------------------------------------------------------------
package cpu_mem_pkg;

  localparam int CPU_DATA_W = 8;
  localparam int CPU_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } prog_state_t;

endpackage

// File: rtl/cpu_mem_prog_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_mem_prog_ctrl
// Programming-port controller. It loads the memory sequentially from address 0
// using a valid/ready handshake and auto-increments the write pointer.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   prog_en      programming mode request; low returns to IDLE next edge
//   prog_valid   prog word offered by the loader
//   prog_ready   word accepted this cycle (high throughout LOAD)
//   prog_done    all DEPTH words loaded
//   prog_err     sticky: a word was offered after the load completed
//   prog_we      write strobe to the memory array
//   prog_addr    write address to the memory array (current pointer)
// -----------------------------------------------------------------------------
module cpu_mem_prog_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_en,
  input  logic              prog_valid,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              prog_err,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  prog_state_t       r_state;
  prog_state_t       w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_accept;

  // An accept depends only on being in LOAD: a word offered on the same edge
  // that prog_en drops is still written before the return to IDLE.
  assign w_accept = (r_state == ST_LOAD) && prog_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_err_nxt   = r_err;

    case (r_state)
      ST_IDLE: begin
        w_ptr_nxt = '0;
        if (prog_en) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          // The accept at the last address wraps the pointer to 0.
          w_ptr_nxt = r_ptr + PTR_ONE;
          if (r_ptr == PTR_LAST) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (prog_valid) begin
          w_err_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase

    // Dropping the request aborts from any state and clears the session.
    if (!prog_en) begin
      w_state_nxt = ST_IDLE;
      w_ptr_nxt   = '0;
      w_err_nxt   = 1'b0;
    end
  end

  assign prog_ready = (r_state == ST_LOAD);
  assign prog_done  = (r_state == ST_DONE);
  assign prog_err   = r_err;
  assign prog_we    = w_accept;
  assign prog_addr  = r_ptr;

endmodule

// File: rtl/cpu_mem_ram.sv
// -----------------------------------------------------------------------------
// cpu_mem_ram
// Writable program/data memory for the SAP CPU (replaces the 16x8 mask ROM).
// Holds a 2^ADDR_W x DATA_W array, the MAR, a registered read-first read port
// and the bus output gate. The array is filled by the programming port before
// the CPU is released, or written by the CPU through ram_we.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   bus_in       CPU bus; low ADDR_W bits feed the MAR, full word feeds writes
//   mar_load     capture bus_in[ADDR_W-1:0] into the MAR
//   ram_we       CPU write of bus_in to mem[MAR] (ignored during LOAD)
//   mem_oe       gate the read register onto bus_out
//   bus_out      read register when mem_oe and not loading, else 0
//   prog_en      programming mode request
//   prog_valid   prog_data valid
//   prog_data    word to load
//   prog_ready   word accepted this cycle
//   prog_done    all words loaded
//   prog_err     sticky overflow flag
//   mar_q        current MAR (debug / LEDs)
// -----------------------------------------------------------------------------
module cpu_mem_ram
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_load,
  input  logic              ram_we,
  input  logic              mem_oe,
  output logic [DATA_W-1:0] bus_out,
  input  logic              prog_en,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              prog_err,
  output logic [ADDR_W-1:0] mar_q
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_rd_q;

  logic              w_prog_we;
  logic [ADDR_W-1:0] w_prog_addr;
  logic              w_prog_ready;
  logic              w_cpu_we;

  cpu_mem_prog_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_prog_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_en    (prog_en),
    .prog_valid (prog_valid),
    .prog_ready (w_prog_ready),
    .prog_done  (prog_done),
    .prog_err   (prog_err),
    .prog_we    (w_prog_we),
    .prog_addr  (w_prog_addr)
  );

  // The CPU has no write path while the loader owns the array.
  assign w_cpu_we = ram_we && !w_prog_ready;

  // MAR: a write issued with mar_load uses the old MAR, since the array
  // write below samples r_mar before this update lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mar <= '0;
    end else if (mar_load) begin
      r_mar <= bus_in[ADDR_W-1:0];
    end
  end

  // Storage is deliberately not reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_prog_we) begin
      r_mem[w_prog_addr] <= prog_data;
    end else if (w_cpu_we) begin
      r_mem[r_mar] <= bus_in;
    end
  end

  // Read-first: a same-edge write to r_mar is seen one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_q <= '0;
    end else begin
      r_rd_q <= r_mem[r_mar];
    end
  end

  assign bus_out    = (mem_oe && !w_prog_ready) ? r_rd_q : '0;
  assign prog_ready = w_prog_ready;
  assign mar_q      = r_mar;

endmodule

// File: tb/tb_cpu_mem_ram.sv
module tb_cpu_mem_ram;

  logic       clk;
  logic       rst_n;

  // Default-size DUT (16 x 8)
  logic [7:0] bus_in;
  logic       mar_load;
  logic       ram_we;
  logic       mem_oe;
  logic [7:0] bus_out;
  logic       prog_en;
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready;
  logic       prog_done;
  logic       prog_err;
  logic [3:0] mar_q;

  // Wide DUT (64 x 16)
  logic [15:0] b_bus_in;
  logic        b_mar_load;
  logic        b_ram_we;
  logic        b_mem_oe;
  logic [15:0] b_bus_out;
  logic        b_prog_en;
  logic        b_prog_valid;
  logic [15:0] b_prog_data;
  logic        b_prog_ready;
  logic        b_prog_done;
  logic        b_prog_err;
  logic [5:0]  b_mar_q;

  int n_vec;
  int n_err;

  // Reference model: memory contents with known-ness, MAR, read register,
  // programming session (mode 0 idle / 1 loading / 2 complete), word count.
  logic [7:0] m_mem [16];
  bit         m_vld [16];
  int         m_mar;
  logic [7:0] m_rd;
  bit         m_rd_vld;
  int         m_mode;
  int         m_ptr;
  bit         m_err;

  cpu_mem_ram u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_in     (bus_in),
    .mar_load   (mar_load),
    .ram_we     (ram_we),
    .mem_oe     (mem_oe),
    .bus_out    (bus_out),
    .prog_en    (prog_en),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .prog_err   (prog_err),
    .mar_q      (mar_q)
  );

  cpu_mem_ram #(
    .DATA_W (16),
    .ADDR_W (6)
  ) u_dut_wide (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_in     (b_bus_in),
    .mar_load   (b_mar_load),
    .ram_we     (b_ram_we),
    .mem_oe     (b_mem_oe),
    .bus_out    (b_bus_out),
    .prog_en    (b_prog_en),
    .prog_valid (b_prog_valid),
    .prog_data  (b_prog_data),
    .prog_ready (b_prog_ready),
    .prog_done  (b_prog_done),
    .prog_err   (b_prog_err),
    .mar_q      (b_mar_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] exp_bus;
    bit         bus_known;
    chk("mar_q", {28'd0, mar_q}, m_mar);
    chk("prog_ready", {31'd0, prog_ready}, (m_mode == 1) ? 1 : 0);
    chk("prog_done", {31'd0, prog_done}, (m_mode == 2) ? 1 : 0);
    chk("prog_err", {31'd0, prog_err}, {31'd0, m_err});
    bus_known = 1'b1;
    exp_bus   = 8'h00;
    if (mem_oe && m_mode != 1) begin
      exp_bus   = m_rd;
      bus_known = m_rd_vld;
    end
    if (bus_known) chk("bus_out", {24'd0, bus_out}, {24'd0, exp_bus});
  endtask

  task automatic model_reset();
    m_mar    = 0;
    m_rd     = 8'h00;
    m_rd_vld = 1'b1;
    m_mode   = 0;
    m_ptr    = 0;
    m_err    = 1'b0;
  endtask

  task automatic clear_inputs();
    bus_in = '0; mar_load = 0; ram_we = 0; mem_oe = 0;
    prog_en = 0; prog_valid = 0; prog_data = '0;
    b_bus_in = '0; b_mar_load = 0; b_ram_we = 0; b_mem_oe = 0;
    b_prog_en = 0; b_prog_valid = 0; b_prog_data = '0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare the small DUT 1 time unit later.
  task automatic tick();
    logic [7:0] rd_new;
    bit         rd_vld_new;
    bit         accepted;
    bit         was_last;
    @(posedge clk);
    rd_new     = m_mem[m_mar];
    rd_vld_new = m_vld[m_mar];
    accepted   = 1'b0;
    was_last   = 1'b0;
    if (m_mode == 1 && prog_valid) begin
      m_mem[m_ptr] = prog_data;
      m_vld[m_ptr] = 1'b1;
      accepted     = 1'b1;
      was_last     = (m_ptr == 15);
      m_ptr        = (m_ptr + 1) % 16;
    end else if (m_mode != 1 && ram_we) begin
      m_mem[m_mar] = bus_in;
      m_vld[m_mar] = 1'b1;
    end
    if (mar_load) m_mar = int'(bus_in) % 16;
    if (!prog_en) begin
      m_mode = 0; m_ptr = 0; m_err = 1'b0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: if (accepted && was_last) m_mode = 2;
        default: if (prog_valid) m_err = 1'b1;
      endcase
    end
    m_rd     = rd_new;
    m_rd_vld = rd_vld_new;
    #1;
    check_outputs();
  endtask

  task automatic reset_mid_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mar_q", {28'd0, mar_q}, 0);
    chk("rst_bus_out", {24'd0, bus_out}, 0);
    chk("rst_prog_ready", {31'd0, prog_ready}, 0);
    chk("rst_prog_done", {31'd0, prog_done}, 0);
    chk("rst_prog_err", {31'd0, prog_err}, 0);
    chk("rst_b_ready", {31'd0, b_prog_ready}, 0);
    model_reset();
    clear_inputs();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int guard;
    int idx;
    logic [7:0] saved;

    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 8'h00;
      m_vld[i] = 1'b0;
    end
    model_reset();
    clear_inputs();
    mem_oe = 1'b1;
    rst_n  = 1'b0;
    #3;
    chk("init_bus_out", {24'd0, bus_out}, 0);
    chk("init_mar_q", {28'd0, mar_q}, 0);
    chk("init_prog_ready", {31'd0, prog_ready}, 0);
    chk("init_prog_done", {31'd0, prog_done}, 0);
    chk("init_prog_err", {31'd0, prog_err}, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    mem_oe = 1'b0;

    // Full load 0x10..0x1F with prog_valid held
    prog_en = 1'b1;
    tick();
    chk("load_ready_entry", {31'd0, prog_ready}, 1);
    prog_valid = 1'b1;
    cnt = 0; guard = 0; idx = 0;
    while (!prog_done && guard < 40) begin
      prog_data = 8'h10 + 8'(idx);
      if (prog_ready) begin cnt++; idx++; end
      tick();
      guard++;
    end
    prog_valid = 1'b0;
    chk("load_ready_cycles", cnt, 16);
    chk("load_done", {31'd0, prog_done}, 1);

    // Read address 5 back through the bus
    prog_en = 1'b0; mar_load = 1'b1; bus_in = 8'hF5; mem_oe = 1'b1;
    tick();
    mar_load = 1'b0; bus_in = 8'h00;
    tick();
    chk("load_read_addr5", {24'd0, bus_out}, 32'h15);

    // Backpressure load with random gaps, then overflow
    prog_en = 1'b1; mem_oe = 1'b0;
    tick();
    guard = 0;
    while (m_mode != 2 && guard < 200) begin
      prog_valid = 1'($urandom_range(0, 1));
      prog_data  = 8'($urandom);
      tick();
      guard++;
    end
    chk("bp_done", {31'd0, prog_done}, 1);
    prog_valid = 1'b1; prog_data = 8'hEE;
    tick();
    chk("overflow_err", {31'd0, prog_err}, 1);
    prog_valid = 1'b0;
    tick();
    chk("overflow_sticky", {31'd0, prog_err}, 1);
    prog_en = 1'b0;
    tick();
    chk("overflow_clear", {31'd0, prog_err}, 0);

    // CPU write, read-first behaviour
    mar_load = 1'b1; bus_in = 8'h03; mem_oe = 1'b1;
    tick();
    mar_load = 1'b0;
    saved = m_mem[3];
    ram_we = 1'b1; bus_in = 8'hA5;
    tick();
    chk("read_first_old", {24'd0, bus_out}, {24'd0, saved});
    ram_we = 1'b0; bus_in = 8'h00;
    tick();
    chk("cpu_write_read", {24'd0, bus_out}, 32'hA5);

    // mar_load and ram_we together: write at old MAR, then MAR moves
    mar_load = 1'b1; bus_in = 8'h02;
    tick();
    ram_we = 1'b1; bus_in = 8'h07;
    tick();
    chk("simul_mar", {28'd0, mar_q}, 7);
    ram_we = 1'b0; bus_in = 8'h02;
    tick();
    mar_load = 1'b0;
    tick();
    chk("simul_mem2", {24'd0, bus_out}, 32'h07);

    // Lockout during LOAD
    mar_load = 1'b1; bus_in = 8'h09;
    tick();
    mar_load = 1'b0;
    saved = m_mem[9];
    prog_en = 1'b1;
    tick();
    ram_we = 1'b1; bus_in = 8'hC3;
    tick();
    chk("lock_bus_out", {24'd0, bus_out}, 0);
    ram_we = 1'b0; prog_en = 1'b0;
    tick();
    tick();
    chk("lock_word_kept", {24'd0, bus_out}, {24'd0, saved});

    // Reset in the middle of a load
    prog_en = 1'b1;
    tick();
    prog_valid = 1'b1; prog_data = 8'h5A;
    tick();
    tick();
    reset_mid_cycle();

    // Randomised mixed traffic, including prog_en drops with a word offered
    for (int n = 0; n < 400; n++) begin
      bus_in     = 8'($urandom);
      mar_load   = ($urandom_range(0, 3) == 0);
      ram_we     = ($urandom_range(0, 3) == 0);
      mem_oe     = 1'($urandom_range(0, 1));
      prog_en    = ($urandom_range(0, 7) != 0);
      prog_valid = 1'($urandom_range(0, 1));
      prog_data  = 8'($urandom);
      tick();
    end
    clear_inputs();
    tick();

    // Wide instance: 64-word load
    b_prog_en = 1'b1;
    tick();
    chk("wide_ready_entry", {31'd0, b_prog_ready}, 1);
    b_prog_valid = 1'b1;
    cnt = 0; guard = 0; idx = 0;
    while (!b_prog_done && guard < 120) begin
      b_prog_data = 16'hA000 + 16'(idx);
      if (b_prog_ready) begin cnt++; idx++; end
      tick();
      guard++;
    end
    b_prog_valid = 1'b0;
    chk("wide_ready_cycles", cnt, 64);
    chk("wide_done", {31'd0, b_prog_done}, 1);
    chk("wide_err", {31'd0, b_prog_err}, 0);
    b_prog_en = 1'b0; b_mar_load = 1'b1; b_bus_in = 16'h0025; b_mem_oe = 1'b1;
    tick();
    b_mar_load = 1'b0;
    tick();
    chk("wide_mar", {26'd0, b_mar_q}, 32'h25);
    chk("wide_read", {16'd0, b_bus_out}, 32'hA025);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
